// File: rtl/ram_dp_be.sv
// ram_dp_be
// Simple dual-port synchronous RAM. It has one byte-enabled write port and
// one independent read port. Read latency is 1 or 2 edges, and the
// same-address collision mode is selectable. A clear engine zeroes the whole
// array after every reset, and busy is high while it runs.
module ram_dp_be #(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     wadr,
  input  logic [DW-1:0]     din,
  input  logic              re,
  input  logic [AW-1:0]     radr,
  output logic [DW-1:0]     dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int NB                = DW / 8;
  localparam int DEPTH             = 1 << AW;
  localparam logic [AW-1:0] LAST_ADR = {AW{1'b1}};
  localparam bit WR_FIRST_B        = (WR_FIRST != 0);
  localparam bit LAT2              = (RD_LAT >= 2);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Replace the enabled byte lanes of old_w with the matching lanes of new_w.
  function automatic logic [DW-1:0] merge_bytes(
    input logic [DW-1:0] old_w,
    input logic [DW-1:0] new_w,
    input logic [NB-1:0] en
  );
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Storage array
  logic [DW-1:0] mem_q [DEPTH];

  // Control state
  state_e        state_q;
  logic [AW-1:0] clr_adr_q;

  // Datapath and qualifiers
  logic          ready_s;
  logic          clr_we_s;
  logic          wr_en_s;
  logic          rd_acc_s;
  logic          coll_s;
  logic [DW-1:0] rd_old_s;
  logic [DW-1:0] rd_word_s;
  logic          stage_valid_s;
  logic [DW-1:0] stage_data_s;

  // Output registers
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;

  // busy is a pure decode of the state register, so accesses are never accepted during clear.
  assign ready_s  = (state_q == ST_READY);
  assign busy     = ~ready_s;

  // Clear engine and FSM: walks every address once after reset, then parks in READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_adr_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_adr_q <= clr_adr_q + AW'(1'b1);
          if (clr_adr_q == LAST_ADR) begin
            state_q <= ST_READY;
          end else begin
            state_q <= ST_CLEAR;
          end
        end
        ST_READY: begin
          state_q   <= ST_READY;
          clr_adr_q <= '0;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_adr_q <= '0;
        end
      endcase
    end
  end

  // Qualify the port strobes. Reset masks everything, and the clear owns the write port while busy.
  always_comb begin
    clr_we_s = 1'b0;
    wr_en_s  = 1'b0;
    rd_acc_s = 1'b0;
    coll_s   = 1'b0;
    if (reset) begin
      clr_we_s = 1'b0;
      wr_en_s  = 1'b0;
      rd_acc_s = 1'b0;
      coll_s   = 1'b0;
    end else begin
      clr_we_s = ~ready_s;
      wr_en_s  = ready_s & we;
      rd_acc_s = ready_s & re;
      coll_s   = ready_s & we & (wadr == radr);
    end
  end

  // Array write: clear zeroes one word per edge, and a normal write updates only its enabled byte lanes.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[clr_adr_q] <= '0;
    end else if (wr_en_s) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[wadr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Read word selection: with write-first, a same-address write is forwarded into the read.
  always_comb begin
    rd_old_s  = mem_q[radr];
    rd_word_s = rd_old_s;
    if (WR_FIRST_B && coll_s) begin
      rd_word_s = merge_bytes(rd_old_s, din, be);
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  generate
    if (LAT2) begin : g_lat2
      logic [DW-1:0] p1_data_q;
      logic          p1_valid_q;

      // Extra pipeline stage for two-edge latency. Reset flushes any in-flight read.
      always_ff @(posedge clk) begin
        if (reset) begin
          p1_valid_q <= 1'b0;
          p1_data_q  <= '0;
        end else begin
          p1_valid_q <= rd_acc_s;
          if (rd_acc_s) begin
            p1_data_q <= rd_word_s;
          end else begin
            p1_data_q <= p1_data_q;
          end
        end
      end

      assign stage_valid_s = p1_valid_q;
      assign stage_data_s  = p1_data_q;
    end else begin : g_lat1
      assign stage_valid_s = rd_acc_s;
      assign stage_data_s  = rd_word_s;
    end
  endgenerate

  // Output stage: dout holds between reads, and dout_valid pulses once per completed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= stage_valid_s;
      if (stage_valid_s) begin
        dout_q <= stage_data_s;
      end else begin
        dout_q <= dout_q;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
